// File: rtl/ip_codma_rd_burst_engine_pkg.sv
// ip_codma_rd_burst_engine_pkg: read-burst FSM states and legacy transfer-size codes
package ip_codma_rd_burst_engine_pkg;
    typedef enum logic [2:0] {RD_IDLE, RD_ASK, RD_DATA, RD_DONE, RD_ERR} rd_burst_state_t;
    localparam int SIZE_1W = 3;
    localparam int SIZE_4W = 8;
    localparam int SIZE_8W = 9;
    function automatic int size_to_len(input int size);
        return size == SIZE_1W ? 1 : size == SIZE_4W ? 4 : size == SIZE_8W ? 8 : 0;
    endfunction
endpackage

// File: rtl/ip_codma_rd_burst_engine_if.sv
// ip_codma_rd_burst_engine_if: read bus between the burst engine and the bus fabric
interface ip_codma_rd_burst_engine_if #(
    parameter int ADDR_W = 32,
    parameter int BUS_DW = 64,
    parameter int CNT_W = 4
);
    logic req;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0] beats;
    logic grant;
    logic read_valid;
    logic [BUS_DW-1:0] read_data;
    logic error;
    modport master(output req, addr, beats, input grant, read_valid, read_data, error);
    modport slave(input req, addr, beats, output grant, read_valid, read_data, error);
endinterface

// File: rtl/ip_codma_word_capture.sv
// ip_codma_word_capture: word bank filled beat by beat at the write index, masked to the burst length
module ip_codma_word_capture #(
    parameter int WORD_W = 32,
    parameter int BUS_DW = 64,
    parameter int MAX_WORDS = 8,
    localparam int CNT_W = $clog2(MAX_WORDS) + 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        clr_i,
    input  logic                        wr_i,
    input  logic [CNT_W-1:0]            len_i,
    input  logic [BUS_DW-1:0]           beat_i,
    output logic                        last_o,
    output logic [CNT_W-1:0]            words_o,
    output logic [MAX_WORDS*WORD_W-1:0] data_o
);
    localparam int WPB = BUS_DW / WORD_W;
    logic [CNT_W-1:0] words_q, words_d, room;
    logic [MAX_WORDS*WORD_W-1:0] data_q, data_d;
    always_comb begin
        room = len_i - words_q;
        words_d = clr_i ? '0 : wr_i ? words_q + (room > CNT_W'(WPB) ? CNT_W'(WPB) : room) : words_q;
        last_o = wr_i && room <= CNT_W'(WPB);
        data_d = data_q;
        for (int k = 0; k < WPB; k++)
            if (wr_i && int'(words_q) + k < int'(len_i))
                data_d[(int'(words_q) + k) * WORD_W +: WORD_W] = beat_i[k * WORD_W +: WORD_W];
    end
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            words_q <= '0;
            data_q <= '0;
        end else begin
            words_q <= words_d;
            data_q <= data_d;
        end
    assign words_o = words_q;
    assign data_o = data_q;
endmodule

// File: rtl/ip_codma_rd_burst_engine.sv
// ip_codma_rd_burst_engine: bus read-burst FSM with grant timeout feeding the word capture bank
module ip_codma_rd_burst_engine
    import ip_codma_rd_burst_engine_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BUS_DW = 64,
    parameter int MAX_WORDS = 8,
    parameter int ADDR_W = 32,
    parameter int TIMEOUT_CYC = 255,
    localparam int CNT_W = $clog2(MAX_WORDS) + 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [CNT_W-1:0]            len_i,
    input  logic                        stop_i,
    ip_codma_rd_burst_engine_if.master  bus,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [CNT_W-1:0]            words_o,
    output logic [MAX_WORDS*WORD_W-1:0] data_o
);
    localparam int WPB = BUS_DW / WORD_W;
    localparam int TO_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
    rd_burst_state_t state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] len_q, len_d, beats_q, beats_d;
    logic error_q, error_d, accept, wr, last;
    assign wr = state_q == RD_DATA && bus.read_valid && !bus.error && !stop_i;
    always_comb begin
        state_d = state_q;
        wait_d = wait_q;
        addr_d = addr_q;
        len_d = len_q;
        beats_d = beats_q;
        accept = 1'b0;
        if (state_q == RD_IDLE) begin
            accept = start_i && len_i != '0 && len_i <= CNT_W'(MAX_WORDS);
            state_d = accept ? RD_ASK : start_i ? RD_ERR : RD_IDLE;
            if (accept) begin
                wait_d = '0;
                addr_d = addr_i;
                len_d = len_i;
                beats_d = CNT_W'((int'(len_i) + WPB - 1) / WPB);
            end
        end else if (bus.error)
            state_d = RD_ERR;
        else if (stop_i)
            state_d = RD_IDLE;
        else
            case (state_q)
                RD_ASK:
                    if (bus.grant)
                        state_d = RD_DATA;
                    else if (TIMEOUT_CYC != 0 && int'(wait_q) == TIMEOUT_CYC - 1)
                        state_d = RD_ERR;
                    else
                        wait_d = wait_q + 1'b1;
                RD_DATA: state_d = last ? RD_DONE : RD_DATA;
                default: state_d = RD_IDLE;
            endcase
        // sticky until the next accepted start
        error_d = state_d == RD_ERR || (error_q && !accept);
    end
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state_q <= RD_IDLE;
            wait_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            beats_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            addr_q <= addr_d;
            len_q <= len_d;
            beats_q <= beats_d;
            error_q <= error_d;
        end
    ip_codma_word_capture #(.WORD_W(WORD_W), .BUS_DW(BUS_DW), .MAX_WORDS(MAX_WORDS)) u_capture (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .clr_i(accept),
        .wr_i(wr),
        .len_i(len_q),
        .beat_i(bus.read_data),
        .last_o(last),
        .words_o(words_o),
        .data_o(data_o)
    );
    assign bus.req = state_q == RD_ASK || state_q == RD_DATA;
    assign bus.addr = addr_q;
    assign bus.beats = beats_q;
    assign busy_o = state_q != RD_IDLE;
    assign done_o = state_q == RD_DONE;
    assign error_o = error_q;
endmodule

// File: tb/tb_ip_codma_rd_burst_engine.sv
// tb_ip_codma_rd_burst_engine: directed and random bursts checked every cycle against a word-level model
module tb_ip_codma_rd_burst_engine;
    import ip_codma_rd_burst_engine_pkg::*;
    localparam int W = 32, DW = 64, MW = 8, AW = 32, TO = 4, WPB = DW / W, CW = $clog2(MW) + 1;
    logic clk_i = 0, reset_n_i = 0, start_i = 0, stop_i = 0, chk_en = 0;
    logic [AW-1:0] addr_i = '0;
    logic [CW-1:0] len_i = '0;
    logic busy_o, done_o, error_o;
    logic [CW-1:0] words_o;
    logic [MW*W-1:0] data_o;
    int checks = 0, passes = 0;
    int m_phase, m_wait, m_words, m_len, m_beats;
    logic m_err;
    logic [AW-1:0] m_addr;
    logic [W-1:0] bank [MW];

    ip_codma_rd_burst_engine_if #(.ADDR_W(AW), .BUS_DW(DW), .CNT_W(CW)) bus ();
    ip_codma_rd_burst_engine #(.WORD_W(W), .BUS_DW(DW), .MAX_WORDS(MW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
        .stop_i(stop_i), .bus(bus), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .words_o(words_o), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else passes++;
    endtask

    // Reference model: phase 0 idle, 1 asking, 2 collecting, 3 done, 4 error
    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_phase = 0; m_wait = 0; m_words = 0; m_len = 0; m_beats = 0; m_err = 0; m_addr = '0;
            for (int i = 0; i < MW; i++) bank[i] = '0;
        end else if (m_phase == 0) begin
            if (start_i && len_i >= 1 && len_i <= MW) begin
                m_phase = 1; m_wait = 0; m_len = int'(len_i); m_addr = addr_i; m_words = 0; m_err = 0;
                m_beats = (m_len + WPB - 1) / WPB;
            end else if (start_i) begin
                m_phase = 4; m_err = 1;
            end
        end else if (bus.error) begin
            m_phase = 4; m_err = 1;
        end else if (stop_i) m_phase = 0;
        else if (m_phase == 1) begin
            if (bus.grant) m_phase = 2;
            else begin
                m_wait++;
                if (m_wait == TO) begin m_phase = 4; m_err = 1; end
            end
        end else if (m_phase == 2) begin
            if (bus.read_valid) begin
                for (int k = 0; k < WPB; k++)
                    if (m_words < m_len) begin
                        bank[m_words] = bus.read_data[k*W +: W];
                        m_words++;
                    end
                if (m_words == m_len) m_phase = 3;
            end
        end else m_phase = 0;
    end

    always @(negedge clk_i) if (chk_en) begin
        logic [MW*W-1:0] mb;
        for (int i = 0; i < MW; i++) mb[i*W +: W] = bank[i];
        chk("busy", busy_o, m_phase != 0);
        chk("req", bus.req, m_phase == 1 || m_phase == 2);
        chk("done", done_o, m_phase == 3);
        chk("error", error_o, m_err);
        chk("words", words_o, m_words);
        chk("data", data_o, mb);
        chk("addr", bus.addr, m_addr);
        chk("beats", bus.beats, m_beats);
    end

    task automatic cyc(); @(posedge clk_i); #1; endtask
    task automatic idle();
        start_i = 0; stop_i = 0; bus.grant = 0; bus.read_valid = 0; bus.error = 0;
    endtask
    task automatic go(input int len, input logic [AW-1:0] a);
        start_i = 1; len_i = CW'(len); addr_i = a; cyc(); start_i = 0;
    endtask
    task automatic beat(input logic [DW-1:0] d);
        bus.read_valid = 1; bus.read_data = d; cyc(); bus.read_valid = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        idle(); bus.read_data = '0;
        repeat (3) @(posedge clk_i);
        #1 reset_n_i = 1; chk_en = 1;
        chk("rst_busy", busy_o, 0); chk("rst_req", bus.req, 0); chk("rst_words", words_o, 0);
        chk("rst_data", data_o, 0); chk("rst_error", error_o, 0);
        chk("size_1w", size_to_len(SIZE_1W), 1);
        chk("size_4w", size_to_len(SIZE_4W), 4);
        chk("size_8w", size_to_len(SIZE_8W), 8);
        // len 8, grant after two cycles, four back-to-back beats
        go(8, 32'h1000);
        chk("t1_req", bus.req, 1); chk("t1_addr", bus.addr, 32'h1000); chk("t1_beats", bus.beats, 4);
        cyc(); cyc();
        bus.grant = 1; cyc(); bus.grant = 0;
        for (int k = 0; k < 4; k++) begin
            beat({32'hA000_0000 + 32'(2*k+1), 32'hA000_0000 + 32'(2*k)});
            chk("t1_words", words_o, 2*k + 2);
            chk("t1_done", done_o, k == 3);
        end
        cyc();
        chk("t1_done_end", done_o, 0); chk("t1_busy_end", busy_o, 0);
        for (int i = 0; i < MW; i++) chk("t1_word", data_o[i*W +: W], 32'hA000_0000 + 32'(i));
        // len 3: word 3 keeps its old value
        go(3, 32'h2000);
        bus.grant = 1; cyc(); bus.grant = 0;
        beat({32'hB000_0001, 32'hB000_0000});
        beat({32'hB000_0003, 32'hB000_0002});
        chk("t2_words", words_o, 3); chk("t2_done", done_o, 1);
        chk("t2_w2", data_o[2*W +: W], 32'hB000_0002); chk("t2_w3", data_o[3*W +: W], 32'hA000_0003);
        cyc();
        // grant timeout
        go(2, 32'h3000);
        cyc(); cyc(); cyc();
        chk("t3_err_early", error_o, 0); chk("t3_busy", busy_o, 1);
        cyc();
        chk("t3_err", error_o, 1); chk("t3_busy_err", busy_o, 1); chk("t3_req_err", bus.req, 0);
        cyc();
        chk("t3_busy_end", busy_o, 0); chk("t3_sticky", error_o, 1); chk("t3_nodone", done_o, 0);
        // stop after beat 2
        go(8, 32'h4000);
        chk("t4_errclr", error_o, 0);
        bus.grant = 1; cyc(); bus.grant = 0;
        beat({32'hC000_0001, 32'hC000_0000});
        beat({32'hC000_0003, 32'hC000_0002});
        stop_i = 1; cyc(); stop_i = 0;
        chk("t4_busy", busy_o, 0); chk("t4_words", words_o, 4); chk("t4_done", done_o, 0); chk("t4_err", error_o, 0);
        go(2, 32'h5000);
        chk("t4_words_clr", words_o, 0);
        stop_i = 1; cyc(); stop_i = 0;
        // bus error beats stop
        go(4, 32'h6000);
        bus.grant = 1; cyc(); bus.grant = 0;
        bus.error = 1; stop_i = 1; cyc(); idle();
        chk("t5_err", error_o, 1); chk("t5_busy", busy_o, 1); chk("t5_done", done_o, 0);
        cyc();
        chk("t5_idle", busy_o, 0);
        // illegal lengths
        go(2, 32'h6100);
        stop_i = 1; cyc(); stop_i = 0;
        go(0, 32'h7000);
        chk("t6_err0", error_o, 1); chk("t6_req0", bus.req, 0); chk("t6_busy0", busy_o, 1);
        cyc();
        chk("t6_req0b", bus.req, 0);
        go(9, 32'h7100);
        chk("t6_req9", bus.req, 0); chk("t6_addr9", bus.addr, 32'h6100);
        cyc();
        // async reset mid-burst
        go(8, 32'h8000);
        bus.grant = 1; cyc(); bus.grant = 0;
        beat({32'hD000_0001, 32'hD000_0000});
        #2 reset_n_i = 0;
        #1;
        chk("rst_mid_busy", busy_o, 0); chk("rst_mid_req", bus.req, 0); chk("rst_mid_words", words_o, 0);
        chk("rst_mid_data", data_o, 0); chk("rst_mid_addr", bus.addr, 0);
        @(posedge clk_i); #3 reset_n_i = 1;
        cyc();
        // random bursts
        repeat (80) begin
            int n, l;
            l = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) == 0 ? 0 : 9) : $urandom_range(1, 8);
            go(l, $urandom);
            n = 0;
            while (m_phase != 0 && n < 100) begin
                bus.grant = 1'($urandom_range(0, 1));
                bus.read_valid = $urandom_range(0, 3) != 0;
                bus.read_data = {$urandom, $urandom};
                stop_i = $urandom_range(0, 50) == 0;
                bus.error = $urandom_range(0, 50) == 0;
                start_i = $urandom_range(0, 7) == 0;
                len_i = CW'($urandom_range(0, 15));
                cyc();
                n++;
            end
            idle(); cyc();
            chk("rand_idle", busy_o, 0);
        end
        chk_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
